tone_word_feeder: RTL
=====================

Name: tone_word_feeder

Overview:
- Upstream stage of the audio serializer: generates a stream of 16-bit offset-binary square-wave samples and hands them to the serializer one word at a time.
- Paces its output on the serializer's per-word done pulse and drives the serializer's enable.
- Runs for a programmed word count, or continuously until stopped, then returns the output to midscale.

Parameters:
- DATA_W, 16, sample word width (must match the serializer's data_in width).
- DUR_W, 24, width of the duration/word counter.
- FADE_LOG2, 3, log2 of words per fade step (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a tone when idle
- stop  in  1  single-cycle pulse; requests a graceful end
- half_period  in  16  words per half cycle of the tone; 0 is treated as 1
- amplitude  in  DATA_W-1  magnitude about midscale
- duration  in  DUR_W  words to emit; 0 means continuous until stop
- ser_done  in  1  serializer pulse: current word fully shifted, next word wanted
- data_out  out  DATA_W  word presented to the serializer's data_in
- ser_enable  out  1  drives the serializer's enable
- busy  out  1  high from the PRIME state through the FINISH state
- finished  out  1  single-cycle pulse when a tone ends

Behaviour:
- Reset (async, reset_n=0):
  - data_out=16'h8000, ser_enable=0, busy=0, finished=0.
  - All counters cleared; FSM goes to IDLE.
  - Reset mid-tone aborts immediately with no finished pulse.
- Word values:
  - HI = 16'h8000 + amplitude; LO = 16'h8000 - amplitude (zero-extended, no overflow possible).
  - amplitude=0 gives constant 16'h8000.
- IDLE:
  - data_out=16'h8000, ser_enable=0.
  - start=1 and stop=0: latch half_period (0→1), amplitude, duration; go to PRIME.
  - start and stop in the same cycle: stop wins, remain IDLE.
- PRIME (1 cycle):
  - data_out=HI, ser_enable=1, phase=HI, half_cnt=1, word_cnt=0; go to RUN.
  - The first HI word is valid on the cycle ser_enable first rises.
- RUN, on ser_done:
  - word_cnt+1.
  - If half_cnt==half_period: toggle phase, half_cnt=1. Else half_cnt+1.
  - data_out updates to the new phase word on the next edge (1-cycle latency). data_out is stable between ser_done pulses.
  - Stop condition met: (duration!=0 and word_cnt+1==duration), or a stop request is pending → FINISH.
- RUN, stop pulse with no ser_done that cycle:
  - Set stop_pend; the current word still completes.
  - stop coincident with ser_done ends at that word.
- FINISH (1 cycle):
  - ser_enable=0, data_out=16'h8000, finished=1, clear stop_pend; go to IDLE.
- start while busy: ignored.
- Parameter inputs: changes after the start latch are ignored until the next start.
- ser_done outside RUN: ignored.
- Counter wrap:
  - word_cnt wraps modulo 2^DUR_W in continuous mode with no effect on output.
  - half_cnt never exceeds half_period.
- finished and busy:
  - finished is high only in FINISH.
  - busy=1 in PRIME, RUN and FINISH.

Optional Feature:
- Macro: TONE_FADE_EN.
- Defined:
  - A fade_shift register loads 4 in PRIME.
  - Effective amplitude is amplitude >> fade_shift, applied to both HI and LO.
  - fade_shift decrements by 1 every 2^FADE_LOG2 ser_done pulses until it reaches 0.
  - The first word is 16'h8000 + (amplitude>>4).
- Not defined: full amplitude from the first word. No fade logic or register is present.

Test Plan:
- Basic tone: half_period=2, amplitude=16'h4000, duration=6, start; serializer model pulses ser_done every 20 cycles → data_out sequence C000,C000,4000,4000,C000,C000; then one finished pulse, ser_enable=0, data_out=8000.
- Continuous plus stop: duration=0, half_period=1, amplitude=16'h7FFF → data_out alternates FFFF/0001. Stop pulsed mid-word → the word completes; finished asserts 1 cycle after the next ser_done.
- Edge values: half_period=0, amplitude=0 → behaves as half_period=1, constant 8000. start with stop in the same cycle in IDLE → busy stays 0.
- Busy and done guards: start pulsed during RUN → no restart, word count unaffected. ser_done pulsed in IDLE → no change.
- Reset mid-tone: reset_n low during RUN at word 3 → outputs immediately 8000/0/0/0 with no finished pulse. A fresh start then begins again with HI.
- With TONE_FADE_EN, FADE_LOG2=1, amplitude=16'h1000, half_period=100:
  - data_out = 8100,8100,8200,8200,8400,8400,8800,8800, then 9000 onward.
  - Without the macro: 9000 from the first word.

Source files
------------

// File: rtl/tone_word_feeder.sv
// tone_word_feeder: square-wave offset-binary word source for the audio serializer.
// Emits HI/LO words paced by the serializer's ser_done pulse, for a programmed
// word count or until stopped, then parks the output at midscale.
// Optional build macro TONE_FADE_EN: amplitude fades in from amplitude>>4 to full
// scale, one shift step every 2^FADE_LOG2 words.
module tone_word_feeder #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DUR_W     = 24,
  parameter int unsigned FADE_LOG2 = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       half_period,
  input  logic [DATA_W-2:0] amplitude,
  input  logic [DUR_W-1:0]  duration,
  input  logic              ser_done,
  output logic [DATA_W-1:0] data_out,
  output logic              ser_enable,
  output logic              busy,
  output logic              finished
);

  localparam int unsigned HP_W  = 16;
  localparam int unsigned AMP_W = DATA_W - 1;
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_FINISH} state_t;

  state_t              state_q, state_d;
  logic [HP_W-1:0]     hp_q, hp_d;
  logic [AMP_W-1:0]    amp_q, amp_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [HP_W-1:0]     half_cnt_q, half_cnt_d;
  logic [DUR_W-1:0]    word_cnt_q, word_cnt_d;
  logic                phase_q, phase_d;
  logic                stop_pend_q, stop_pend_d;
  logic [DATA_W-1:0]   data_d;
  logic                en_d, busy_d, fin_d;
  logic [AMP_W-1:0]    amp_eff;
`ifdef TONE_FADE_EN
  logic [2:0]           fade_shift_q, fade_shift_d;
  logic [FADE_LOG2-1:0] fade_cnt_q, fade_cnt_d;
`endif

  // Word for a phase (1 = HI) at a given magnitude about midscale.
  function automatic logic [DATA_W-1:0] word_of(input logic ph, input logic [AMP_W-1:0] a);
    return ph ? (MID + DATA_W'(a)) : (MID - DATA_W'(a));
  endfunction

  // State, latched parameters, counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      hp_q        <= '0;
      amp_q       <= '0;
      dur_q       <= '0;
      half_cnt_q  <= '0;
      word_cnt_q  <= '0;
      phase_q     <= 1'b0;
      stop_pend_q <= 1'b0;
      data_out    <= MID;
      ser_enable  <= 1'b0;
      busy        <= 1'b0;
      finished    <= 1'b0;
`ifdef TONE_FADE_EN
      fade_shift_q <= '0;
      fade_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hp_q        <= hp_d;
      amp_q       <= amp_d;
      dur_q       <= dur_d;
      half_cnt_q  <= half_cnt_d;
      word_cnt_q  <= word_cnt_d;
      phase_q     <= phase_d;
      stop_pend_q <= stop_pend_d;
      data_out    <= data_d;
      ser_enable  <= en_d;
      busy        <= busy_d;
      finished    <= fin_d;
`ifdef TONE_FADE_EN
      fade_shift_q <= fade_shift_d;
      fade_cnt_q   <= fade_cnt_d;
`endif
    end
  end

  // Next-state, counter and output-register logic; outputs are set on state entry.
  always_comb begin
    state_d     = state_q;
    hp_d        = hp_q;
    amp_d       = amp_q;
    dur_d       = dur_q;
    half_cnt_d  = half_cnt_q;
    word_cnt_d  = word_cnt_q;
    phase_d     = phase_q;
    stop_pend_d = stop_pend_q;
    data_d      = data_out;
    en_d        = ser_enable;
    busy_d      = busy;
    fin_d       = 1'b0;
    amp_eff     = amp_q;
`ifdef TONE_FADE_EN
    fade_shift_d = fade_shift_q;
    fade_cnt_d   = fade_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        data_d = MID;
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (start && !stop) begin
          hp_d        = (half_period == '0) ? HP_W'(1) : half_period;
          amp_d       = amplitude;
          dur_d       = duration;
          phase_d     = 1'b1;
          half_cnt_d  = HP_W'(1);
          word_cnt_d  = '0;
          stop_pend_d = 1'b0;
`ifdef TONE_FADE_EN
          fade_shift_d = 3'd4;
          fade_cnt_d   = '0;
          data_d       = word_of(1'b1, amplitude >> 4);
`else
          data_d       = word_of(1'b1, amplitude);
`endif
          en_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = S_PRIME;
        end
      end
      S_PRIME: state_d = S_RUN;
      S_RUN: begin
        if (ser_done) begin
          word_cnt_d = DUR_W'(word_cnt_q + 1'b1);
          if (half_cnt_q == hp_q) begin
            phase_d    = ~phase_q;
            half_cnt_d = HP_W'(1);
          end else begin
            half_cnt_d = HP_W'(half_cnt_q + 1'b1);
          end
`ifdef TONE_FADE_EN
          fade_cnt_d = FADE_LOG2'(fade_cnt_q + 1'b1);
          if (fade_cnt_q == '1 && fade_shift_q != 3'd0)
            fade_shift_d = fade_shift_q - 3'd1;
          amp_eff = amp_q >> fade_shift_d;
`endif
          data_d = word_of(phase_d, amp_eff);
          if ((dur_q != '0 && DUR_W'(word_cnt_q + 1'b1) == dur_q) || stop_pend_q || stop) begin
            data_d  = MID;
            en_d    = 1'b0;
            fin_d   = 1'b1;
            state_d = S_FINISH;
          end
        end else if (stop) begin
          stop_pend_d = 1'b1;
        end
      end
      S_FINISH: begin
        stop_pend_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
